// File: rtl/req_pri_arb_pkg.sv
// Shared definitions for the request priority arbiter: sizes, FSM encoding
// and the one-hot decode used to retire a granted request.
package req_pri_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/req_pri_arb_lowest_idx_enc.sv
// Combinational lowest-set-bit encoder; o_any flags a non-empty vector so the
// caller never has to interpret the index of an all-zero input.
module lowest_idx_enc
  import req_pri_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_vec,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin
    o_any = |i_vec;
    o_idx = 2'd0;
    if (i_vec[0])      o_idx = 2'd0;
    else if (i_vec[1]) o_idx = 2'd1;
    else if (i_vec[2]) o_idx = 2'd2;
    else if (i_vec[3]) o_idx = 2'd3;
  end

endmodule

// File: rtl/req_pri_arb.sv
// Request accumulator and lowest-index arbiter with a valid/ready grant port
// and saturating grant / duplicate-request statistics.
//
// state    | meaning
// ST_IDLE  | nothing offered; waits for any pending bit
// ST_OFFER | o_out_idx held stable until accepted, then reloaded or idle
module req_pri_arb
  import req_pri_arb_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [3:0]         i_req_in,
  input  logic               i_flush,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [1:0]         o_out_idx,
  output logic [3:0]         o_pending,
  output logic [CNT_W-1:0]   o_grant_cnt,
  output logic [CNT_W-1:0]   o_dup_cnt
);

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [NUM_REQ-1:0] r_pending, w_pend_nxt, w_clr_mask;
  logic [CNT_W-1:0]   r_grant_cnt, r_dup_cnt;
  logic               w_accept, w_dup;
  logic [IDX_W-1:0]   w_cur_idx, w_nxt_idx;
  logic               w_cur_any, w_nxt_any;

  assign w_accept   = (r_state == ST_OFFER) && i_out_ready;
  assign w_clr_mask = w_accept ? onehot(r_idx) : '0;
  // Set wins over clear: a re-request of the bit being granted stays pending.
  assign w_pend_nxt = (r_pending & ~w_clr_mask) | i_req_in;
  assign w_dup      = |(i_req_in & r_pending & ~w_clr_mask);

  lowest_idx_enc u_enc_cur (
    .i_vec (r_pending),
    .o_idx (w_cur_idx),
    .o_any (w_cur_any)
  );

  lowest_idx_enc u_enc_nxt (
    .i_vec (w_pend_nxt),
    .o_idx (w_nxt_idx),
    .o_any (w_nxt_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (i_flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cur_any) begin
            w_state_nxt = ST_OFFER;
            w_idx_nxt   = w_cur_idx;
          end
        end
        ST_OFFER: begin
          if (w_accept) begin
            if (w_nxt_any) w_idx_nxt = w_nxt_idx;
            else           w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_pending   <= '0;
      r_grant_cnt <= '0;
      r_dup_cnt   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_pending <= i_flush ? '0 : w_pend_nxt;
      // A grant taken in the flush cycle still counts; discarded requests do not.
      if (w_accept && (r_grant_cnt != '1))
        r_grant_cnt <= r_grant_cnt + CNT_W'(1);
      if (!i_flush && w_dup && (r_dup_cnt != '1))
        r_dup_cnt <= r_dup_cnt + CNT_W'(1);
    end
  end

  assign o_out_valid = (r_state == ST_OFFER);
  assign o_out_idx   = r_idx;
  assign o_pending   = r_pending;
  assign o_grant_cnt = r_grant_cnt;
  assign o_dup_cnt   = r_dup_cnt;

endmodule

// File: tb/tb_req_pri_arb.sv
// Directed bench for req_pri_arb: grant indices are scoreboarded through a
// queue; pending, valid and counters are checked at fixed points.
module tb_req_pri_arb;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req_in;
  logic             flush;
  logic             out_ready;
  logic             out_valid;
  logic [1:0]       out_idx;
  logic [3:0]       pending;
  logic [CNT_W-1:0] grant_cnt;
  logic [CNT_W-1:0] dup_cnt;

  int compared   = 0;
  int mismatched = 0;
  int exp_q[$];

  req_pri_arb #(.CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_in    (req_in),
    .i_flush     (flush),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_idx   (out_idx),
    .o_pending   (pending),
    .o_grant_cnt (grant_cnt),
    .o_dup_cnt   (dup_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_in = 4'd0; flush = 1'b0; out_ready = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  // Grant scoreboard: every accepted handshake must match the next expected index.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", int'(out_idx), -1);
      end else begin
        chk("grant_idx", int'(out_idx), exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req_in = 4'd0; flush = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_pending", pending, 0);
    chk("rst_grant", grant_cnt, 0);
    chk("rst_dup", dup_cnt, 0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // single request, 2-edge latency, one-cycle offer
    out_ready = 1'b1; req_in = 4'b0100; exp_q.push_back(2);
    step(1); req_in = 4'd0;
    chk("single_pend", pending, 4'b0100);
    chk("single_val0", out_valid, 0);
    step(1);
    chk("single_valid", out_valid, 1);
    chk("single_idx", out_idx, 2);
    step(1);
    chk("single_drop", out_valid, 0);
    chk("single_pend0", pending, 0);
    chk("single_grant", grant_cnt, 1);
    chk("single_q", exp_q.size(), 0);

    // priority drain without bubbles
    do_reset();
    out_ready = 1'b1; req_in = 4'b1011;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    step(1); req_in = 4'd0;
    step(1);
    chk("drain_idx0", out_idx, 0);
    step(1);
    chk("drain_idx1", out_idx, 1);
    chk("drain_pend", pending, 4'b1010);
    chk("drain_v1", out_valid, 1);
    step(1);
    chk("drain_idx3", out_idx, 3);
    chk("drain_grant2", grant_cnt, 2);
    step(1);
    chk("drain_valid0", out_valid, 0);
    chk("drain_grant3", grant_cnt, 3);
    chk("drain_q", exp_q.size(), 0);

    // no preemption by a lower index
    do_reset();
    req_in = 4'b1000; exp_q.push_back(3); exp_q.push_back(0);
    step(1); req_in = 4'd0;
    step(1);
    chk("nopre_idx3", out_idx, 3);
    req_in = 4'b0001;
    step(1); req_in = 4'd0;
    chk("nopre_pend", pending, 4'b1001);
    step(2);
    chk("nopre_hold", out_idx, 3);
    chk("nopre_hold_v", out_valid, 1);
    out_ready = 1'b1;
    step(1);
    chk("nopre_next", out_idx, 0);
    chk("nopre_next_v", out_valid, 1);
    step(1);
    chk("nopre_end", out_valid, 0);
    chk("nopre_grant", grant_cnt, 2);

    // collision on the bit being granted
    do_reset();
    req_in = 4'b0010; exp_q.push_back(1); exp_q.push_back(1);
    step(1); req_in = 4'd0;
    step(1);
    chk("coll_idx", out_idx, 1);
    out_ready = 1'b1; req_in = 4'b0010;
    step(1); req_in = 4'd0;
    chk("coll_pend", pending, 4'b0010);
    chk("coll_regrant", out_idx, 1);
    chk("coll_dup", dup_cnt, 0);
    step(1);
    chk("coll_end", out_valid, 0);
    chk("coll_grant", grant_cnt, 2);
    // duplicate request on a held bit
    out_ready = 1'b0; req_in = 4'b0100; exp_q.push_back(2);
    step(1); req_in = 4'd0;
    step(1);
    chk("dup_idx", out_idx, 2);
    req_in = 4'b0100;
    step(1); req_in = 4'd0;
    chk("dup_cnt1", dup_cnt, 1);
    chk("dup_pend", pending, 4'b0100);
    out_ready = 1'b1;
    step(1);
    chk("dup_end", out_valid, 0);
    // two colliding bits in one cycle count once
    out_ready = 1'b0; req_in = 4'b0110;
    exp_q.push_back(1); exp_q.push_back(2);
    step(1);
    step(1); req_in = 4'd0;
    chk("dup_multi", dup_cnt, 2);
    out_ready = 1'b1;
    step(2);
    chk("dup_multi_end", out_valid, 0);
    chk("dup_multi_pend", pending, 0);

    // flush discards requests and the offer
    do_reset();
    req_in = 4'b0101;
    step(1); req_in = 4'd0;
    step(1);
    chk("flush_pre", out_valid, 1);
    flush = 1'b1; req_in = 4'b1111;
    step(1); flush = 1'b0; req_in = 4'd0;
    chk("flush_pend", pending, 0);
    chk("flush_valid", out_valid, 0);
    step(1);
    chk("flush_stay", out_valid, 0);
    // grant accepted in the flush cycle is counted
    req_in = 4'b0001; exp_q.push_back(0);
    step(1); req_in = 4'd0;
    step(1);
    out_ready = 1'b1; flush = 1'b1;
    step(1); flush = 1'b0;
    chk("flush_grant", grant_cnt, 1);
    chk("flush_acc_v", out_valid, 0);

    // saturation of grant_cnt
    do_reset();
    out_ready = 1'b1; req_in = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    step(1); req_in = 4'd0;
    step(5);
    chk("sat_grant4", grant_cnt, 3);
    req_in = 4'b0001; exp_q.push_back(0);
    step(1); req_in = 4'd0;
    step(2);
    chk("sat_grant5", grant_cnt, 3);
    chk("sat_valid", out_valid, 0);

    // async reset mid-offer with out_idx=2
    out_ready = 1'b0; req_in = 4'b0100;
    step(1); req_in = 4'd0;
    step(1);
    chk("arst_pre_idx", out_idx, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_idx", out_idx, 0);
    chk("arst_pend", pending, 0);
    chk("arst_grant", grant_cnt, 0);
    chk("arst_dup", dup_cnt, 0);
    #1;
    rst_n = 1'b1;
    step(2);
    chk("arst_idle", out_valid, 0);

    chk("final_q", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/req_pri_arb.md
Name: req_pri_arb

Overview:
- Sequential front end for the 4-input lowest-index priority encoder stage.
- Accumulates single-cycle request pulses from 4 sources into a pending register.
- Selects the lowest-index pending source and offers its 2-bit index downstream over a valid/ready handshake.
- Clears each request once it is consumed, and keeps grant and collision statistics.

Parameters:
CNT_W, 8, width of the saturating grant_cnt and dup_cnt counters (min 2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_in  in  4  request pulses; bit i=1 sets pending[i]
flush  in  1  synchronous clear of all pending state
out_valid  out  1  out_idx holds a valid grant
out_ready  in  1  downstream accepts the grant this cycle
out_idx  out  2  granted source index, 0 = highest priority
pending  out  4  current pending request register
grant_cnt  out  CNT_W  accepted grants, saturating
dup_cnt  out  CNT_W  requests that hit an already-pending bit, saturating

Behaviour:
- Reset: while rst_n=0, all outputs are held at 0 immediately, independent of clk. Reset is async assert; release takes effect at the next clk edge. Reset mid-handshake drops the offered grant without counting it.
- Encoder function: enc(v) returns the index of the lowest set bit of v; enc(0) is unused. It is purely combinational and has no latches; all cases are fully specified.
- accept = out_valid & out_ready.
- clr_mask = one-hot(out_idx) when accept, else 0.
- Pending update per edge: pending <= (pending & ~clr_mask) | req_in. On a set/clear collision on the same bit, set wins and the bit remains pending.
- dup_cnt increments once per edge if (req_in & pending & ~clr_mask) != 0, regardless of how many bits collide. Saturates at all-ones.
- grant_cnt increments on each accept edge. Saturates at all-ones.
- FSM states:
  - IDLE: out_valid=0. If pending != 0, go to OFFER with out_idx <= enc(pending) and out_valid <= 1.
  - OFFER: out_valid=1. out_idx stays stable until accept, even if a lower-index request arrives meanwhile (no preemption).
    - On accept, let p' be the next pending value. If p' != 0, stay in OFFER with out_idx <= enc(p') (back-to-back, no bubble). Otherwise go to IDLE with out_valid <= 0.
- Latency: req_in sampled at edge E0 sets pending after E0; out_valid rises after E1 (2-edge latency from IDLE).
- Throughput: 1 grant per cycle while out_ready=1 and requests remain.
- flush=1 has priority over all other updates:
  - pending <= 0, out_valid <= 0, state <= IDLE.
  - req_in that cycle is discarded.
  - A grant accepted in the same cycle IS counted in grant_cnt.
  - Counters are not cleared.
- out_ready is ignored while out_valid=0.

Decomposition:
- Shared package holds:
  - NUM_REQ=4 and IDX_W=2
  - state encoding IDLE=1'b0, OFFER=1'b1
  - one-hot decode function for clr_mask
- One sub-module, lowest_idx_enc (4-bit in, 2-bit out, plus any output), instantiated twice: one on pending, one on p'.
- Counters are inline.

Test Plan:
1. Reset: assert rst_n=0 mid-OFFER with out_idx=2 -> all outputs 0 asynchronously before the next clk; after release, state is IDLE.
2. Single request: req_in=4'b0100 for 1 cycle with out_ready=1 -> out_valid high 2 edges later with out_idx=2, for exactly 1 cycle; pending returns to 0; grant_cnt=1.
3. Priority drain: req_in=4'b1011 in one cycle, out_ready=1 -> out_idx sequence 0,1,3 on consecutive cycles with no bubble; out_valid falls after the third grant; grant_cnt=3.
4. No preemption: pending=4'b1000 offered with out_ready=0, then req_in=4'b0001 -> out_idx stays 3 until out_ready=1; next grant is out_idx=0.
5. Collision: while out_idx=1 is being accepted, req_in=4'b0010 -> pending[1] stays 1, a second grant of 1 follows, dup_cnt unchanged. Separately, req_in=4'b0100 while pending[2]=1 and not cleared -> dup_cnt +1.
6. Flush and saturation: flush=1 together with req_in=4'b1111 -> pending=0, out_valid=0 next cycle. With CNT_W=2, run 5 accepted grants -> grant_cnt saturates at 3.
